// File: rtl/vedic64_seq_ctrl.sv
// vedic64_seq_ctrl: 2W x 2W multiply sequencer on one shared W x W multiplier.
// Four partial products, one per cycle, summed in carry-save form and resolved
// into out_p when the sequence finishes.
//
// Ports:
//   clk, rst (sync, active high)
//   in_valid/in_ready/in_a/in_b   : operand handshake (2*W bit operands)
//   mul_en/mul_a/mul_b/mul_p      : shared multiplier port
//   out_valid/out_ready/out_p     : product handshake (4*W bit product)
//   busy                          : high outside IDLE
//   done_cnt                      : products accepted, wraps at 2^CNT_W
//
// Build option: define VEDIC_MUL_PIPE_EN when the multiplier has one cycle of
// latency; this adds a DRAIN state so the last partial product can land.

module vedic64_seq_ctrl #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   in_a,
  input  logic [2*W-1:0]   in_b,
  output logic             mul_en,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*W-1:0]   out_p,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int PW = 4*W;

`ifdef VEDIC_MUL_PIPE_EN
  typedef enum logic [2:0] {
    IDLE, M0, M1, M2, M3, DRAIN, DONE
  } st_t;
`else
  typedef enum logic [2:0] {
    IDLE, M0, M1, M2, M3, DONE
  } st_t;
`endif

  st_t st, st_n;

  logic [2*W-1:0] a_q, b_q;
  logic [PW-1:0]  s_q, c_q;
  logic [PW-1:0]  s_n, c_n;
  logic [PW-1:0]  x;
  logic [1:0]     iss_sh;
  logic [1:0]     add_sh;
  logic           add_en;
  logic           accept;
  logic           fin;

  assign in_ready  = (st == IDLE);
  assign busy      = (st != IDLE);
  assign out_valid = (st == DONE);
  assign accept    = in_valid && (st == IDLE);
  assign fin       = (st != DONE) && (st_n == DONE);

  // Next state and multiplier issue; iss_sh is the
  // partial-product shift in units of W.
  always_comb begin
    st_n   = st;
    mul_en = 1'b0;
    mul_a  = '0;
    mul_b  = '0;
    iss_sh = 2'd0;
    unique case (st)
      IDLE: begin
        if (in_valid) st_n = M0;
      end
      M0: begin
        mul_en = 1'b1;
        mul_a  = a_q[W-1:0];
        mul_b  = b_q[W-1:0];
        iss_sh = 2'd0;
        st_n   = M1;
      end
      M1: begin
        mul_en = 1'b1;
        mul_a  = a_q[W-1:0];
        mul_b  = b_q[2*W-1:W];
        iss_sh = 2'd1;
        st_n   = M2;
      end
      M2: begin
        mul_en = 1'b1;
        mul_a  = a_q[2*W-1:W];
        mul_b  = b_q[W-1:0];
        iss_sh = 2'd1;
        st_n   = M3;
      end
      M3: begin
        mul_en = 1'b1;
        mul_a  = a_q[2*W-1:W];
        mul_b  = b_q[2*W-1:W];
        iss_sh = 2'd2;
`ifdef VEDIC_MUL_PIPE_EN
        st_n   = DRAIN;
`else
        st_n   = DONE;
`endif
      end
`ifdef VEDIC_MUL_PIPE_EN
      DRAIN: begin
        st_n = DONE;
      end
`endif
      DONE: begin
        if (out_ready) st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

`ifdef VEDIC_MUL_PIPE_EN
  // Product arrives a cycle after issue, so the
  // shift travels with it through a register.
  logic       pend_q;
  logic [1:0] psh_q;

  assign add_en = pend_q;
  assign add_sh = psh_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      psh_q  <= 2'd0;
    end else begin
      pend_q <= mul_en;
      psh_q  <= iss_sh;
    end
  end
`else
  assign add_en = mul_en;
  assign add_sh = iss_sh;
`endif

  always_comb begin
    x = '0;
    if (add_en) begin
      unique case (add_sh)
        2'd0:    x[2*W-1:0]  = mul_p;
        2'd1:    x[3*W-1:W]  = mul_p;
        default: x[PW-1:2*W] = mul_p;
      endcase
    end
  end

  // 3:2 compression; carry out of the top bit is
  // dropped since the exact product fits in PW bits.
  assign s_n = s_q ^ c_q ^ x;
  assign c_n = ((s_q & c_q) | (s_q & x) | (c_q & x)) << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      c_q      <= '0;
      out_p    <= '0;
      done_cnt <= '0;
    end else begin
      st <= st_n;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
        s_q <= '0;
        c_q <= '0;
      end else if (add_en) begin
        s_q <= s_n;
        c_q <= c_n;
      end
      if (fin) out_p <= s_n + c_n;
      if (out_valid && out_ready)
        done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vedic64_seq_ctrl.sv
// tb_vedic64_seq_ctrl: randomized self-checking bench for vedic64_seq_ctrl.
// Products are compared against full-width integer multiplication.

module tb_vedic64_seq_ctrl;

  localparam int W     = 32;
  localparam int CNT_W = 2;
`ifdef VEDIC_MUL_PIPE_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2*W-1:0]   in_a = '0;
  logic [2*W-1:0]   in_b = '0;
  logic             mul_en;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   mul_p;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [4*W-1:0]   out_p;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  int lat;
  logic [127:0] got;
  logic [63:0]  mq[$];
  logic         idle_mul_bad;

  always #5 clk = ~clk;

  // Shared multiplier model
`ifdef VEDIC_MUL_PIPE_EN
  always @(posedge clk)
    mul_p <= {32'd0, mul_a} * {32'd0, mul_b};
`else
  assign mul_p = {32'd0, mul_a} * {32'd0, mul_b};
`endif

  vedic64_seq_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .mul_en(mul_en), .mul_a(mul_a),
    .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .busy(busy),
    .done_cnt(done_cnt)
  );

  function automatic logic [127:0] model(
    input logic [63:0] a, input logic [63:0] b);
    logic [127:0] x, y;
    x = {64'd0, a};
    y = {64'd0, b};
    return x * y;
  endfunction

  // Expected {mul_a, mul_b} for issue slot k
  function automatic logic [63:0] pair(
    input logic [63:0] a, input logic [63:0] b, input int k);
    logic [31:0] ha, hb;
    ha = (k >= 2) ? a[63:32] : a[31:0];
    hb = (k % 2 == 1) ? b[63:32] : b[31:0];
    return {ha, hb};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [CNT_W-1:0] cnt_exp(input int n);
    return CNT_W'(n % (1 << CNT_W));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair and run until out_valid or a 20-cycle bound.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    mq.delete();
    idle_mul_bad = 1'b0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (mul_en) mq.push_back({mul_a, mul_b});
      else if (mul_a != 0 || mul_b != 0) idle_mul_bad = 1'b1;
      tick();
      lat++;
    end
    got = out_p;
  endtask

  task automatic accept_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    n_chk++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs rdy=%b busy=%b vld=%b want 1 0 0",
               in_ready, busy, out_valid);
    end
    n_chk++;
    if (mul_en !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin
      n_fail++;
      $display("FAIL reset_mul en=%b a=%h b=%h want 0 0 0",
               mul_en, mul_a, mul_b);
    end
    n_chk++;
    if (out_p !== '0 || done_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_out p=%h cnt=%0d want 0 0", out_p, done_cnt);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_basic();
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready got %b want 1", in_ready);
    end
    start_op(64'd3, 64'd5);
    n_chk++;
    if (got !== model(64'd3, 64'd5)) begin
      n_fail++;
      $display("FAIL basic_p got %0d want 15", got);
    end
    n_chk++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL basic_latency got %0d want %0d edges", lat, LAT);
    end
    n_chk++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done busy=%b rdy=%b want 1 0", busy, in_ready);
    end
    accept_out();
    n_chk++;
    if (done_cnt !== cnt_exp(exp_cnt)) begin
      n_fail++;
      $display("FAIL basic_cnt got %0d want %0d", done_cnt, cnt_exp(exp_cnt));
    end
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_max();
    logic [63:0]  m;
    logic [127:0] e;
    m = '1;
    e = model(m, m);
    start_op(m, m);
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL max_p got %h want %h", got, e);
    end
    accept_out();
  endtask

  task automatic test_halves();
    logic [63:0] a;
    a = 64'h1_0000_0000;
    start_op(a, a);
    n_chk++;
    if (got !== model(a, a)) begin
      n_fail++;
      $display("FAIL halves_p got %h want %h", got, model(a, a));
    end
    n_chk++;
    if (mq.size() != 4) begin
      n_fail++;
      $display("FAIL halves_issues got %0d want 4", mq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (mq[k] !== pair(a, a, k)) begin
          n_fail++;
          $display("FAIL halves_m%0d got %h want %h", k, mq[k], pair(a, a, k));
        end
      end
    end
    accept_out();
  endtask

  task automatic test_backpressure();
    logic [63:0]  a, b;
    logic [127:0] e;
    a = rnd64();
    b = rnd64();
    e = model(a, b);
    start_op(a, b);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a = rnd64();
      in_b = rnd64();
      n_chk++;
      if (out_valid !== 1'b1 || out_p !== e || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d vld=%b rdy=%b p=%h want 1 0 %h",
                 i, out_valid, in_ready, out_p, e);
      end
      tick();
    end
    in_valid = 1'b0;
    accept_out();
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release rdy=%b vld=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
    n_chk++;
    if (done_cnt !== cnt_exp(exp_cnt)) begin
      n_fail++;
      $display("FAIL bp_cnt got %0d want %0d", done_cnt, cnt_exp(exp_cnt));
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] a, b;
    a = rnd64();
    b = rnd64();
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_chk++;
    if (mul_en !== 1'b1 || {mul_a, mul_b} !== pair(a, b, 2)) begin
      n_fail++;
      $display("FAIL mid_m2 en=%b ab=%h want 1 %h",
               mul_en, {mul_a, mul_b}, pair(a, b, 2));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    n_chk++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || mul_en !== 1'b0 ||
        mul_a !== '0 || mul_b !== '0) begin
      n_fail++;
      $display("FAIL mid_rst rdy=%b busy=%b en=%b a=%h b=%h want 1 0 0 0 0",
               in_ready, busy, mul_en, mul_a, mul_b);
    end
    n_chk++;
    if (out_p !== '0 || done_cnt !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_out p=%h cnt=%0d vld=%b want 0 0 0",
               out_p, done_cnt, out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_discard%0d vld=%b busy=%b want 0 0",
                 i, out_valid, busy);
      end
      tick();
    end
    start_op(64'd7, 64'd9);
    n_chk++;
    if (got !== model(64'd7, 64'd9)) begin
      n_fail++;
      $display("FAIL mid_new_p got %0d want 63", got);
    end
    accept_out();
    n_chk++;
    if (done_cnt !== cnt_exp(exp_cnt)) begin
      n_fail++;
      $display("FAIL mid_cnt got %0d want %0d", done_cnt, cnt_exp(exp_cnt));
    end
  endtask

  task automatic test_cnt_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      start_op(64'($urandom_range(0, 1000)), 64'($urandom_range(0, 1000)));
      accept_out();
      n_chk++;
      if (done_cnt !== cnt_exp(k + 1)) begin
        n_fail++;
        $display("FAIL wrap_cnt%0d got %0d want %0d",
                 k, done_cnt, cnt_exp(k + 1));
      end
    end
  endtask

  task automatic test_random();
    logic [63:0]  a, b;
    logic [127:0] e;
    int d;
    for (int t = 0; t < 20; t++) begin
      a = rnd64();
      b = rnd64();
      if (t == 3) a = '0;
      if (t == 4) b = '1;
      e = model(a, b);
      start_op(a, b);
      n_chk++;
      if (got !== e || lat !== LAT) begin
        n_fail++;
        $display("FAIL rand%0d_p got %h lat %0d want %h lat %0d",
                 t, got, lat, e, LAT);
      end
      n_chk++;
      if (mq.size() != 4 || idle_mul_bad !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_issues got %0d idle_bad=%b want 4 0",
                 t, mq.size(), idle_mul_bad);
      end else begin
        for (int k = 0; k < 4; k++) begin
          n_chk++;
          if (mq[k] !== pair(a, b, k)) begin
            n_fail++;
            $display("FAIL rand%0d_m%0d got %h want %h",
                     t, k, mq[k], pair(a, b, k));
          end
        end
      end
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_p !== e) begin
        n_fail++;
        $display("FAIL rand%0d_held vld=%b p=%h want 1 %h",
                 t, out_valid, out_p, e);
      end
      accept_out();
      n_chk++;
      if (done_cnt !== cnt_exp(exp_cnt)) begin
        n_fail++;
        $display("FAIL rand%0d_cnt got %0d want %0d",
                 t, done_cnt, cnt_exp(exp_cnt));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] q[$];
    int           acc_t[$];
    int           nacc;
    logic         took;
    logic [127:0] e;
    nacc = 0;
    in_a = rnd64();
    in_b = rnd64();
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (out_valid) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_spurious out_valid at %0d", i);
        end else begin
          e = q.pop_front();
          exp_cnt++;
          if (out_p !== e) begin
            n_fail++;
            $display("FAIL b2b_p got %h want %h", out_p, e);
          end
        end
      end
      took = in_valid && in_ready;
      if (took) begin
        q.push_back(model(in_a, in_b));
        acc_t.push_back(i);
        nacc++;
      end
      tick();
      if (took) begin
        in_a = rnd64();
        in_b = rnd64();
        if (nacc == 4) in_valid = 1'b0;
      end
      if (nacc == 4 && q.size() == 0) break;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_chk++;
    if (nacc != 4 || q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count accepted %0d pending %0d want 4 0",
               nacc, q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (acc_t[k+1] - acc_t[k] != LAT + 2) begin
          n_fail++;
          $display("FAIL b2b_gap%0d got %0d want %0d",
                   k, acc_t[k+1] - acc_t[k], LAT + 2);
        end
      end
    end
    n_chk++;
    if (done_cnt !== cnt_exp(exp_cnt)) begin
      n_fail++;
      $display("FAIL b2b_cnt got %0d want %0d", done_cnt, cnt_exp(exp_cnt));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_halves();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
